// File: rtl/commu_tp_chk_pkg.sv
// ---------------------------------------------------------------------------
// commu_tp_chk_pkg : pattern bytes, FSM encodings and helpers shared by
//                    the test-pattern checker and generator.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package commu_tp_chk_pkg;

  typedef logic [7:0]  tp_byte_t;
  typedef logic [1:0]  tp_idx_t;
  typedef logic [1:0]  tp_state_t;
  typedef logic [15:0] tp_cnt_t;

  localparam tp_byte_t PAT_0 = 8'h55;
  localparam tp_byte_t PAT_1 = 8'hAA;
  localparam tp_byte_t PAT_2 = 8'h5A;
  localparam tp_byte_t PAT_3 = 8'hA5;

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam tp_cnt_t CNT_MAX = 16'hFFFF;

  function automatic tp_cnt_t sat_inc(input tp_cnt_t v);
    return (v == CNT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/commu_tp_chk_if.sv
// ---------------------------------------------------------------------------
// commu_tp_chk_if : byte stream, configuration and status bundle.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface commu_tp_chk_if
  import commu_tp_chk_pkg::*;
  ();

  logic     tp_vld;
  tp_byte_t tp_d;
  tp_byte_t cfg_tp;
  logic     tp_lock;
  logic     tp_err;
  tp_cnt_t  err_cnt;
  tp_cnt_t  ok_cnt;

  modport master (
    output tp_vld, tp_d, cfg_tp,
    input  tp_lock, tp_err, err_cnt, ok_cnt
  );

  modport slave (
    input  tp_vld, tp_d, cfg_tp,
    output tp_lock, tp_err, err_cnt, ok_cnt
  );

endinterface

`default_nettype wire

// File: rtl/commu_tp_pat.sv
// ---------------------------------------------------------------------------
// commu_tp_pat : phase index to expected pattern byte lookup.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module commu_tp_pat
  import commu_tp_chk_pkg::*;
  (
  input  tp_idx_t  idx,
  output tp_byte_t pat
);

  always_comb begin
    pat = PAT_0;
    case (idx)
      2'd0:    pat = PAT_0;
      2'd1:    pat = PAT_1;
      2'd2:    pat = PAT_2;
      2'd3:    pat = PAT_3;
      default: pat = PAT_0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/commu_tp_chk.sv
// ---------------------------------------------------------------------------
// commu_tp_chk : locks onto the 55/AA/5A/A5 test pattern and counts
//                matching / mismatching bytes while locked.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module commu_tp_chk
  import commu_tp_chk_pkg::*;
  #(
  parameter int LOCK_N = 4,
  parameter int LOSS_N = 3
) (
  input  logic            clk_sys,
  input  logic            rst_n,
  commu_tp_chk_if.slave   tp
);

  // run counts matches after the hunt byte, so locking needs LOCK_N-1 of them
  localparam logic [3:0] c_run_tgt  = 4'(LOCK_N - 1);
  localparam logic [3:0] c_miss_tgt = 4'(LOSS_N);

  tp_state_t       r_state;
  tp_idx_t         r_idx;
  logic [3:0]      r_run;
  logic [3:0]      r_miss;
  logic            r_lock;
  logic            r_err;
  tp_cnt_t         r_err_cnt;
  tp_cnt_t         r_ok_cnt;

  tp_byte_t        w_exp_byte;
  tp_byte_t [3:0]  w_hunt_byte;
  logic     [3:0]  w_hunt_hit;
  tp_idx_t         w_hunt_idx;
  logic            w_match;
  logic            w_en;
  logic            w_clr;
  logic            w_lck_byte;
  logic            w_cfg_unused;

  assign w_en         = tp.cfg_tp[0];
  assign w_clr        = tp.cfg_tp[1];
  assign w_cfg_unused = &{1'b0, tp.cfg_tp[7:2]};

  commu_tp_pat u_pat_exp (
    .idx (r_idx),
    .pat (w_exp_byte)
  );

  generate
    for (genvar g = 0; g < 4; g++) begin : g_hunt
      commu_tp_pat u_pat_hunt (
        .idx (2'(g)),
        .pat (w_hunt_byte[g])
      );
      assign w_hunt_hit[g] = (tp.tp_d == w_hunt_byte[g]);
    end
  endgenerate

  // pattern values are distinct, so at most one hit bit is ever set
  always_comb begin
    w_hunt_idx = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (w_hunt_hit[k]) w_hunt_idx = 2'(k);
    end
  end

  assign w_match    = (tp.tp_d == w_exp_byte);
  assign w_lck_byte = w_en & tp.tp_vld & (r_state == ST_LOCKED);

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_HUNT;
      r_idx   <= 2'd0;
      r_run   <= 4'd0;
      r_miss  <= 4'd0;
      r_lock  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (!w_en) begin
        r_state <= ST_HUNT;
        r_idx   <= 2'd0;
        r_run   <= 4'd0;
        r_miss  <= 4'd0;
        r_lock  <= 1'b0;
      end else if (tp.tp_vld) begin
        case (r_state)
          ST_HUNT: begin
            if (|w_hunt_hit) begin
              r_idx <= w_hunt_idx + 2'd1;
              r_run <= 4'd0;
              if (c_run_tgt == 4'd0) begin
                r_state <= ST_LOCKED;
                r_lock  <= 1'b1;
                r_miss  <= 4'd0;
              end else begin
                r_state <= ST_VERIFY;
              end
            end
          end
          ST_VERIFY: begin
            if (w_match) begin
              r_idx <= r_idx + 2'd1;
              r_run <= r_run + 4'd1;
              if (r_run + 4'd1 == c_run_tgt) begin
                r_state <= ST_LOCKED;
                r_lock  <= 1'b1;
                r_miss  <= 4'd0;
              end
            end else begin
              r_state <= ST_HUNT;
              r_run   <= 4'd0;
            end
          end
          ST_LOCKED: begin
            r_idx <= r_idx + 2'd1;
            if (w_match) begin
              r_miss <= 4'd0;
            end else begin
              r_err  <= 1'b1;
              r_miss <= r_miss + 4'd1;
              if (r_miss + 4'd1 == c_miss_tgt) begin
                r_state <= ST_HUNT;
                r_lock  <= 1'b0;
                r_run   <= 4'd0;
              end
            end
          end
          default: begin
            r_state <= ST_HUNT;
            r_lock  <= 1'b0;
          end
        endcase
      end
    end
  end

  // clear has priority over any increment in the same cycle
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= 16'd0;
      r_ok_cnt  <= 16'd0;
    end else if (w_clr) begin
      r_err_cnt <= 16'd0;
      r_ok_cnt  <= 16'd0;
    end else if (w_lck_byte) begin
      if (w_match) r_ok_cnt  <= sat_inc(r_ok_cnt);
      else         r_err_cnt <= sat_inc(r_err_cnt);
    end
  end

  assign tp.tp_lock = r_lock;
  assign tp.tp_err  = r_err;
  assign tp.err_cnt = r_err_cnt;
  assign tp.ok_cnt  = r_ok_cnt;

endmodule

`default_nettype wire

// File: tb/tb_commu_tp_chk.sv
// ---------------------------------------------------------------------------
// tb_commu_tp_chk : scoreboard bench for two checker configurations
//                   (4/3 and 1/15) fed with the same byte stream.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_commu_tp_chk;

  localparam int HUNT = 0, VERIFY = 1, LOCKED = 2;

  typedef struct {
    int st; int idx; int streak; int misses; int ec; int oc; bit err;
  } mdl_t;

  typedef struct packed {
    logic l1; logic e1; logic [15:0] ec1; logic [15:0] oc1;
    logic l2; logic e2; logic [15:0] ec2; logic [15:0] oc2;
  } exp_t;

  logic clk_sys = 1'b0;
  logic rst_n   = 1'b0;
  always #5 clk_sys = ~clk_sys;

  commu_tp_chk_if bus1 ();
  commu_tp_chk_if bus2 ();

  commu_tp_chk #(.LOCK_N(4), .LOSS_N(3)) u_dut1 (
    .clk_sys (clk_sys), .rst_n (rst_n), .tp (bus1.slave));
  commu_tp_chk #(.LOCK_N(1), .LOSS_N(15)) u_dut2 (
    .clk_sys (clk_sys), .rst_n (rst_n), .tp (bus2.slave));

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];
  mdl_t m1, m2;
  logic cur_clr = 1'b0;

  function automatic logic [7:0] pat_of(input int k);
    case (k % 4)
      0: return 8'h55;
      1: return 8'hAA;
      2: return 8'h5A;
      default: return 8'hA5;
    endcase
  endfunction

  function automatic int sat(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  // Reference: count consecutive matches including the hunt byte; lock at lock_n.
  function automatic mdl_t mdl_next(input mdl_t m, input int lock_n, input int loss_n,
                                    input bit rstn, input bit en, input bit clr,
                                    input bit vld, input logic [7:0] d);
    mdl_t r = m;
    r.err = 1'b0;
    if (!rstn) begin
      r = '{HUNT, 0, 0, 0, 0, 0, 1'b0};
      return r;
    end
    if (!en) begin
      r.st = HUNT; r.streak = 0; r.misses = 0;
    end else if (vld) begin
      if (r.st == HUNT) begin
        for (int k = 0; k < 4; k++) begin
          if (d == pat_of(k)) begin
            r.idx = (k + 1) % 4;
            r.streak = 1;
            r.st = (r.streak >= lock_n) ? LOCKED : VERIFY;
            r.misses = 0;
          end
        end
      end else if (r.st == VERIFY) begin
        if (d == pat_of(r.idx)) begin
          r.idx = (r.idx + 1) % 4;
          r.streak++;
          if (r.streak >= lock_n) begin r.st = LOCKED; r.misses = 0; end
        end else begin
          r.st = HUNT;
        end
      end else begin
        if (d == pat_of(r.idx)) begin
          r.oc = sat(r.oc); r.misses = 0;
        end else begin
          r.err = 1'b1; r.ec = sat(r.ec); r.misses++;
          if (r.misses == loss_n) r.st = HUNT;
        end
        r.idx = (r.idx + 1) % 4;
      end
    end
    if (clr) begin r.ec = 0; r.oc = 0; end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input bit rstn, input bit en, input bit clr, input bit vld,
                      input logic [7:0] d);
    exp_t e;
    @(negedge clk_sys);
    rst_n = rstn;
    bus1.cfg_tp = {6'b101010, clr, en};
    bus2.cfg_tp = {6'b010101, clr, en};
    bus1.tp_vld = vld; bus2.tp_vld = vld;
    bus1.tp_d   = d;   bus2.tp_d   = d;
    m1 = mdl_next(m1, 4, 3, rstn, en, clr, vld, d);
    m2 = mdl_next(m2, 1, 15, rstn, en, clr, vld, d);
    e.l1 = (m1.st == LOCKED); e.e1 = m1.err; e.ec1 = 16'(m1.ec); e.oc1 = 16'(m1.oc);
    e.l2 = (m2.st == LOCKED); e.e2 = m2.err; e.ec2 = 16'(m2.ec); e.oc2 = 16'(m2.oc);
    sb.push_back(e);
  endtask

  task automatic send(input logic [7:0] d);
    step(1'b1, 1'b1, cur_clr, 1'b1, d);
  endtask

  task automatic gap();
    step(1'b1, 1'b1, cur_clr, 1'b0, 8'h55);
  endtask

  task automatic chk_zero_now(input string tag);
    #1;
    chk({tag, "_lock1"}, 16'(bus1.tp_lock), 16'd0);
    chk({tag, "_err1"},  16'(bus1.tp_err),  16'd0);
    chk({tag, "_ec1"},   bus1.err_cnt,      16'd0);
    chk({tag, "_oc1"},   bus1.ok_cnt,       16'd0);
    chk({tag, "_lock2"}, 16'(bus2.tp_lock), 16'd0);
    chk({tag, "_ec2"},   bus2.err_cnt,      16'd0);
  endtask

  // Monitor: outputs are presented every cycle; compare one cycle after the drive.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_sys);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("lock1", 16'(bus1.tp_lock), 16'(e.l1));
        chk("err1",  16'(bus1.tp_err),  16'(e.e1));
        chk("ecnt1", bus1.err_cnt,      e.ec1);
        chk("ocnt1", bus1.ok_cnt,       e.oc1);
        chk("lock2", 16'(bus2.tp_lock), 16'(e.l2));
        chk("err2",  16'(bus2.tp_err),  16'(e.e2));
        chk("ecnt2", bus2.err_cnt,      e.ec2);
        chk("ocnt2", bus2.ok_cnt,       e.oc2);
      end
    end
  end

  initial begin
    int r;
    logic [7:0] d;
    m1 = '{HUNT, 0, 0, 0, 0, 0, 1'b0};
    m2 = '{HUNT, 0, 0, 0, 0, 0, 1'b0};
    bus1.tp_vld = 1'b0; bus2.tp_vld = 1'b0;
    bus1.tp_d = 8'h00;  bus2.tp_d = 8'h00;
    bus1.cfg_tp = 8'h00; bus2.cfg_tp = 8'h00;

    step(1'b0, 1'b1, 1'b0, 1'b1, 8'h55);
    chk_zero_now("reset");
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'hAA);

    // hunt on 5A, lock after 4th byte, then two counted matches
    send(8'h5A); send(8'hA5); gap(); send(8'h55); send(8'hAA);
    send(8'h5A); send(8'hA5);
    // single injected error, lock held, following A5 matches
    send(8'h55); send(8'hAA); send(8'h00); send(8'hA5);
    // three consecutive errors drop lock; 55 restarts VERIFY; 5A aborts it
    send(8'h00); send(8'h00); gap(); gap(); send(8'h00);
    send(8'h55); send(8'h5A); send(8'h13);

    // randomized traffic with occasional disable, clear and reset
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 6)      d = pat_of(m1.idx);
      else if (r < 8) d = pat_of(int'($urandom_range(0, 3)));
      else            d = 8'($urandom);
      cur_clr = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 299) == 0) begin
        step(1'b0, 1'b1, 1'b0, 1'b1, d);
        chk_zero_now("rand_rst");
      end else begin
        step(1'b1, ($urandom_range(0, 49) != 0), cur_clr,
             ($urandom_range(0, 3) != 0), d);
      end
    end
    cur_clr = 1'b0;

    // reset mid-LOCKED with valid high, then relock and drop enable
    for (int i = 0; i < 6; i++) send(pat_of(m1.idx));
    step(1'b0, 1'b1, 1'b0, 1'b1, pat_of(m1.idx));
    chk_zero_now("mid_rst");
    send(8'hAA);
    for (int i = 0; i < 6; i++) send(pat_of(m1.idx));
    step(1'b1, 1'b0, 1'b0, 1'b1, pat_of(m1.idx));
    step(1'b1, 1'b0, 1'b0, 1'b1, pat_of(m1.idx));
    for (int i = 0; i < 6; i++) send(pat_of(m1.idx));

    // drive the deep-loss checker's error counter into saturation
    send(8'hA5);
    for (int n = 0; n < 4700; n++) begin
      for (int j = 0; j < 14; j++) send(8'h00);
      send(pat_of(m2.idx));
    end
    @(posedge clk_sys); #2;
    chk("sat_ec2", bus2.err_cnt, 16'hFFFF);
    for (int j = 0; j < 5; j++) send(8'h00);
    cur_clr = 1'b1;
    send(8'h00);
    cur_clr = 1'b0;
    send(8'h00);

    @(posedge clk_sys); @(posedge clk_sys); #2;
    chk("sb_drain", 16'(sb.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/commu_tp_chk.md
COMMU_TP_CHK -- requirements
Module: commu_tp_chk

Interface
REQ-001 SHALL have parameter LOCK_N, default 4, consecutive matching bytes in VERIFY needed to reach LOCKED (range 1..15).
REQ-002 SHALL have parameter LOSS_N, default 3, consecutive mismatching bytes in LOCKED that force return to HUNT (range 1..15).
REQ-003 SHALL have port clk_sys  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port tp_vld  input  1  received byte strobe, one byte per cycle while high.
REQ-006 SHALL have port tp_d  input  8  received test-pattern byte, sampled when tp_vld=1.
REQ-007 SHALL have port cfg_tp  input  8  configuration: bit0 enable, bit1 counter clear (level), bits7:2 reserved and ignored.
REQ-008 SHALL have port tp_lock  output  1  checker locked to pattern phase.
REQ-009 SHALL have port tp_err  output  1  one-cycle pulse per mismatching byte while LOCKED.
REQ-010 SHALL have port err_cnt  output  16  mismatch count while LOCKED, saturating.
REQ-011 SHALL have port ok_cnt  output  16  matching-byte count while LOCKED, saturating.

Function
REQ-012 Expected sequence SHALL be 8'h55, 8'hAA, 8'h5A, 8'hA5 at phase index 0..3, wrapping 3->0.
REQ-013 States SHALL be HUNT, VERIFY, LOCKED; only bytes with tp_vld=1 cause transitions or counting.
REQ-014 HUNT: byte equal to any of the four values SHALL set expected index to (matched index+1) mod 4, clear match run, go VERIFY; other bytes SHALL keep HUNT.
REQ-015 VERIFY: matching byte SHALL advance index and increment run; run reaching LOCK_N-1 after the hunt byte SHALL go LOCKED (LOCK_N total matches including hunt byte); mismatch SHALL go HUNT.
REQ-016 LOCK_N=1 SHALL go directly HUNT->LOCKED on the hunt byte.
REQ-017 LOCKED: every valid byte SHALL advance index regardless of match.
REQ-018 LOCKED match SHALL increment ok_cnt and clear miss run; mismatch SHALL pulse tp_err, increment err_cnt, increment miss run.
REQ-019 Miss run reaching LOSS_N SHALL go HUNT and deassert tp_lock; that last byte still counts in err_cnt.
REQ-020 tp_lock SHALL be high exactly while state is LOCKED.
REQ-021 All outputs SHALL be registered; effect of a byte sampled at edge N SHALL be visible after edge N (latency 1 cycle).
REQ-022 err_cnt and ok_cnt SHALL saturate at 16'hFFFF, never wrap.
REQ-023 cfg_tp[1]=1 SHALL hold both counters at 0; clear SHALL win over a simultaneous increment; state machine unaffected.
REQ-024 cfg_tp[0]=0 SHALL force HUNT, tp_lock=0, tp_err=0, ignore tp_vld; counters SHALL hold value.
REQ-025 Enable deasserted mid-LOCKED SHALL drop lock the next cycle; re-enable SHALL restart from HUNT.
REQ-026 tp_vld gaps of any length SHALL not affect state, index or runs.

Reset
REQ-027 rst_n low SHALL immediately set state HUNT, index 0, runs 0, tp_lock=0, tp_err=0, err_cnt=0, ok_cnt=0.
REQ-028 Reset asserted mid-sequence SHALL discard phase; first valid byte after release SHALL be treated as a hunt byte.

Structure
REQ-029 Pattern byte constants (55/AA/5A/A5) and state encodings SHALL live in a shared definition include used by this block and the pattern generator.
REQ-030 Index-to-byte lookup SHALL be one combinational sub-module, commu_tp_pat, shared with the generator.
REQ-031 No other sub-modules; no memories.

Verification
REQ-032 Enable, stream 5A,A5,55,AA,5A,A5 -> hunt on 5A, tp_lock=1 after 4th byte, ok_cnt=2, err_cnt=0.
REQ-033 Locked, inject 00 in place of 5A once -> single tp_err pulse, err_cnt=1, lock held, next 8'hA5 counts as match.
REQ-034 Locked, three consecutive 00 bytes -> err_cnt=3, tp_lock=0 after third, state HUNT; a following 55 restarts VERIFY.
REQ-035 VERIFY after 55, send 5A (expected AA) -> back to HUNT, tp_lock never asserted, counters unchanged.
REQ-036 Preload err_cnt near 16'hFFFF via forced errors, continue errors -> holds FFFF; assert cfg_tp[1] with simultaneous error -> counters 0.
REQ-037 Assert rst_n low mid-LOCKED with tp_vld high -> all outputs 0 immediately; clear cfg_tp[0] while locked -> tp_lock=0 next cycle, counters held.
